if_pc_gen: RTL and testbench
============================

// Module: if_pc_gen
// PURPOSE
// Fetch PC generator: owns the architectural fetch PC register and feeds IF0 every cycle.
// Selects the next PC from four sources: backend redirect, pending redirect, predictor
// redirect, and sequential nPC (IF0's 8-byte-group increment). Holds the PC on
// downstream stall and buffers one redirect that arrives during a stall.
// PARAMETERS
// RESET_PC   32'hBFC0_0000   fetch address after reset (MIPS boot vector)
// PORTS
// clk            in   1   clock
// rst_n          in   1   synchronous reset, active low
// stall_i        in   1   IF1/ICache cannot accept a new PC; hold pc_o
// seq_npc_i      in   32  sequential next PC computed by IF0 from pc_o
// bp_redirect_i  in   1   branch-predictor redirect request (one-cycle pulse)
// bp_target_i    in   32  predictor target, valid with bp_redirect_i
// be_redirect_i  in   1   backend redirect: mispredict/exception/eret (one-cycle pulse)
// be_target_i    in   32  backend target, valid with be_redirect_i
// pc_o           out  32  current fetch PC to IF0
// pc_valid_o     out  1   pc_o is a real fetch request
// flush_o        out  1   flush IF pipeline registers downstream
// BEHAVIOUR
// - Reset: pc_o=RESET_PC, pc_valid_o=0, pending cleared, state=BOOT. flush_o=0.
// - All targets are word-aligned on capture: bits [1:0] forced to 0.
// - States: BOOT, RUN, STALL, STALL_PEND.
//   BOOT       -> RUN next cycle unconditionally; pc_o stays RESET_PC; pc_valid_o=1 in RUN.
//   RUN        -> !stall_i: pc_o <= next (priority be > bp > seq_npc_i), stay RUN.
//                 stall_i & be: pend <= be_target, kind=BE -> STALL_PEND.
//                 stall_i & bp & !be: pend <= bp_target, kind=BP -> STALL_PEND.
//                 stall_i, no redirect -> STALL.
//   STALL      -> pc_o held. Redirect capture identical to RUN-with-stall.
//                 !stall_i & no redirect: pc_o <= seq_npc_i -> RUN.
//                 !stall_i & redirect: pc_o <= target (be > bp) -> RUN.
//   STALL_PEND -> pc_o held. New be overwrites pend (kind=BE). New bp overwrites only
//                 if kind=BP. !stall_i: pc_o <= be_target_i if be this cycle, else pend;
//                 pend cleared -> RUN.
// - be and bp in the same cycle: be wins; bp dropped.
// - be_redirect_i while !stall_i: takes effect on the next edge (1-cycle latency).
// - be_redirect_i while stalled: pc_o changes on the first edge with stall_i=0.
// - pc_valid_o=1 in RUN/STALL/STALL_PEND and 0 in BOOT.
// - flush_o = be_redirect_i, combinational, in any state except BOOT/reset.
// - seq_npc_i is ignored in BOOT and whenever a redirect/pending target is selected.
// - Reset mid-operation: rst_n=0 at an edge overrides everything. Pending redirect is
//   lost; next state is BOOT.
// TESTING
// 1 Reset, then 4 free cycles with IF0 in loop -> pc_o: BFC00000 (BOOT, valid=0),
//   BFC00000 (valid=1), BFC00008, BFC00010.
// 2 pc_o=BFC00008, stall_i=1 for 3 cycles -> pc_o stays BFC00008; releases to BFC00010.
// 3 Stall; be_redirect_i with target 80001233 at cycle 1 -> flush_o=1 that cycle,
//   pc_o held. Release -> pc_o=80001230.
// 4 Stall; bp target 80000100, then be target 80000200, then bp target 80000300 ->
//   release gives pc_o=80000200.
// 5 RUN: be (80000040) and bp (80000080) in the same cycle -> next pc_o=80000040,
//   flush_o=1 for that one cycle.
// 6 Pending redirect held, rst_n=0 for 1 cycle -> pc_o=BFC00000 with valid=0, then
//   valid=1; pending target never appears.

Source files
------------

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch PC generator.
// Owns the architectural fetch PC and presents it to IF0 every cycle. The next PC
// comes from a backend redirect, a buffered (pending) redirect, a predictor
// redirect, or IF0's sequential nPC. The PC is held while downstream stalls, and
// one redirect arriving during a stall is buffered until the stall clears.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   stall_i        IF1/ICache cannot accept a new PC; hold pc_o
//   seq_npc_i      sequential next PC from IF0 (derived from pc_o)
//   bp_redirect_i  predictor redirect pulse, target on bp_target_i
//   be_redirect_i  backend redirect pulse, target on be_target_i
//   pc_o           current fetch PC
//   pc_valid_o     pc_o is a real fetch request
//   flush_o        flush downstream IF pipeline registers
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic [31:0] seq_npc_i,
  input  logic        bp_redirect_i,
  input  logic [31:0] bp_target_i,
  input  logic        be_redirect_i,
  input  logic [31:0] be_target_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, STALL_PEND} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_be_q, pend_be_d;  // pending entry came from the backend

  // Targets are word-aligned on capture.
  logic [31:0] be_tgt, bp_tgt;
  assign be_tgt = {be_target_i[31:2], 2'b00};
  assign bp_tgt = {bp_target_i[31:2], 2'b00};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_q    <= '0;
      pend_be_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_be_q <= pend_be_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:        state_d = RUN;
      RUN, STALL: begin
        if (!stall_i)                            state_d = RUN;
        else if (be_redirect_i || bp_redirect_i) state_d = STALL_PEND;
        else                                     state_d = STALL;
      end
      STALL_PEND:  state_d = stall_i ? STALL_PEND : RUN;
      default:     state_d = BOOT;
    endcase
  end

  // PC / pending-redirect datapath
  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_be_d = pend_be_q;
    case (state_q)
      RUN, STALL: begin
        if (!stall_i) begin
          if (be_redirect_i)      pc_d = be_tgt;
          else if (bp_redirect_i) pc_d = bp_tgt;
          else                    pc_d = seq_npc_i;
        end else if (be_redirect_i) begin
          pend_d    = be_tgt;
          pend_be_d = 1'b1;
        end else if (bp_redirect_i) begin
          pend_d    = bp_tgt;
          pend_be_d = 1'b0;
        end
      end
      STALL_PEND: begin
        if (!stall_i) begin
          // A backend redirect in the release cycle is newer than anything buffered.
          pc_d      = be_redirect_i ? be_tgt : pend_q;
          pend_d    = '0;
          pend_be_d = 1'b0;
        end else if (be_redirect_i) begin
          pend_d    = be_tgt;
          pend_be_d = 1'b1;
        end else if (bp_redirect_i && !pend_be_q) begin
          // A predictor redirect must never displace a buffered backend redirect.
          pend_d = bp_tgt;
        end
      end
      default: ;  // BOOT: hold RESET_PC
    endcase
  end

  // Outputs
  always_comb begin
    pc_o       = pc_q;
    pc_valid_o = (state_q != BOOT);
    flush_o    = rst_n && be_redirect_i && (state_q != BOOT);
  end

endmodule

// File: tb/tb_if_pc_gen.sv
module tb_if_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] seq_npc_i;
  logic        bp_redirect_i;
  logic [31:0] bp_target_i;
  logic        be_redirect_i;
  logic [31:0] be_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;

  always #5 clk = ~clk;

  // IF0 in the loop: 8-byte fetch group increment.
  assign seq_npc_i = pc_o + 32'd8;

  if_pc_gen dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .seq_npc_i(seq_npc_i),
    .bp_redirect_i(bp_redirect_i), .bp_target_i(bp_target_i),
    .be_redirect_i(be_redirect_i), .be_target_i(be_target_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o)
  );

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        vld;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: mid-cycle, pop the expectation for this cycle and compare outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (pc_o !== e.pc) begin
        bad++;
        $display("FAIL pc cyc%0d: got %h want %h", e.id, pc_o, e.pc);
      end
      total++;
      if (pc_valid_o !== e.vld) begin
        bad++;
        $display("FAIL valid cyc%0d: got %b want %b", e.id, pc_valid_o, e.vld);
      end
      total++;
      if (flush_o !== e.fl) begin
        bad++;
        $display("FAIL flush cyc%0d: got %b want %b", e.id, flush_o, e.fl);
      end
    end
  end

  int cyc = 0;

  // One cycle: drive inputs just after the edge, queue what outputs must show.
  task automatic step(input logic rst, input logic st,
                      input logic be, input logic [31:0] bet,
                      input logic bp, input logic [31:0] bpt,
                      input logic [31:0] epc, input logic evld, input logic efl);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; stall_i = st;
    be_redirect_i = be; be_target_i = bet;
    bp_redirect_i = bp; bp_target_i = bpt;
    cyc++;
    e.id = cyc; e.pc = epc; e.vld = evld; e.fl = efl;
    exp_q.push_back(e);
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    rst_n = 1'b0; stall_i = 1'b0;
    be_redirect_i = 1'b0; be_target_i = Z;
    bp_redirect_i = 1'b0; bp_target_i = Z;
    repeat (2) @(posedge clk);

    // Boot and free run
    step(1,0, 0,Z, 0,Z, 32'hBFC00000, 0, 0);
    step(1,0, 0,Z, 0,Z, 32'hBFC00000, 1, 0);
    // Plain stall at BFC00008 for 3 cycles
    step(1,1, 0,Z, 0,Z, 32'hBFC00008, 1, 0);
    step(1,1, 0,Z, 0,Z, 32'hBFC00008, 1, 0);
    step(1,1, 0,Z, 0,Z, 32'hBFC00008, 1, 0);
    step(1,0, 0,Z, 0,Z, 32'hBFC00008, 1, 0);
    // Stall with an unaligned backend redirect
    step(1,1, 0,Z, 0,Z, 32'hBFC00010, 1, 0);
    step(1,1, 1,32'h80001233, 0,Z, 32'hBFC00010, 1, 1);
    step(1,1, 0,Z, 0,Z, 32'hBFC00010, 1, 0);
    step(1,0, 0,Z, 0,Z, 32'hBFC00010, 1, 0);
    // bp, then be, then bp while stalled: be must survive
    step(1,1, 0,Z, 1,32'h80000100, 32'h80001230, 1, 0);
    step(1,1, 1,32'h80000200, 0,Z, 32'h80001230, 1, 1);
    step(1,1, 0,Z, 1,32'h80000300, 32'h80001230, 1, 0);
    step(1,0, 0,Z, 0,Z, 32'h80001230, 1, 0);
    // be and bp together in RUN: be wins
    step(1,0, 1,32'h80000040, 1,32'h80000080, 32'h80000200, 1, 1);
    step(1,0, 0,Z, 0,Z, 32'h80000040, 1, 0);
    // bp redirect in RUN, unaligned target
    step(1,0, 0,Z, 1,32'h80000083, 32'h80000048, 1, 0);
    // Stall then release with a bp in the release cycle
    step(1,1, 0,Z, 0,Z, 32'h80000080, 1, 0);
    step(1,0, 0,Z, 1,32'h80000500, 32'h80000080, 1, 0);
    // Pending be, then reset: pending target must never appear
    step(1,1, 1,32'h80000600, 0,Z, 32'h80000500, 1, 1);
    step(0,1, 1,32'h80000700, 0,Z, 32'h80000500, 1, 0);
    step(1,0, 1,32'h80000800, 0,Z, 32'hBFC00000, 0, 0);
    step(1,0, 0,Z, 0,Z, 32'hBFC00000, 1, 0);
    step(1,0, 0,Z, 0,Z, 32'hBFC00008, 1, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
